// File: rtl/bus_arb.sv
// bus_arb: shares the single external memory bus between the instruction-fetch
// refill port (I) and the data refill/writeback port (D). Each grant is a
// BEATS-long line burst. The arbiter generates the beat addresses and steers the
// beat acknowledges. An atomic lock lets D keep the bus across several bursts.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_req/i_addr/i_ack  I-port request, line address, beat acknowledge
//   d_req/d_we/d_addr   D-port request, write flag, line address
//   d_wdata/d_ack       D-port write data for the current beat, beat acknowledge
//   amo_req/amo_ack     atomic lock request, lock-held indication
//   rdata               read data, combinational pass-through of b_rdata
//   b_*                 external bus beat interface
//   gnt                 status: 00 idle, 01 I, 10 D
module bus_arb #(
  parameter int unsigned BEATS = 8,
  parameter int unsigned AW    = 64,
  parameter int unsigned DW    = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  input  logic          amo_req,
  output logic          amo_ack,
  output logic [DW-1:0] rdata,
  output logic          b_req,
  output logic          b_we,
  output logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_wdata,
  input  logic [DW-1:0] b_rdata,
  input  logic          b_ack,
  output logic [1:0]    gnt
);

  localparam int unsigned BW         = $clog2(BEATS);
  localparam int unsigned LINE_BYTES = BEATS * DW / 8;
  localparam int unsigned BYTE_OFF   = $clog2(DW / 8);
  localparam logic [AW-1:0] OFF_MASK = AW'(LINE_BYTES - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  // Encoding doubles as the gnt status value.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          last_d_q, last_d_d;   // 1: D won the last burst
  logic          lock_q, lock_d;
  logic          active_q, active_d;   // a burst is in flight (b_req held regardless of req)
  logic          b_req_c;
  logic [AW-1:0] sel_addr_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      last_d_q <= 1'b1;
      lock_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      last_d_q <= last_d_d;
      lock_q   <= lock_d;
      active_q <= active_d;
    end
  end

  // Bus-side outputs and acknowledge steering.
  always_comb begin
    b_req_c    = 1'b0;
    b_we       = 1'b0;
    b_wdata    = '0;
    i_ack      = 1'b0;
    d_ack      = 1'b0;
    sel_addr_c = '0;
    unique case (state_q)
      GNT_I: begin
        b_req_c    = 1'b1;
        sel_addr_c = i_addr;
        b_wdata    = d_wdata;
        i_ack      = b_ack;
      end
      GNT_D: begin
        // Between locked bursts the bus idles until D asks again.
        b_req_c    = active_q | d_req;
        sel_addr_c = d_addr;
        b_we       = d_we;
        b_wdata    = d_wdata;
        d_ack      = b_ack & b_req_c;
      end
      default: ;
    endcase
  end

  assign b_req   = b_req_c;
  assign b_addr  = (state_q == IDLE) ? '0
                 : ((sel_addr_c & ~OFF_MASK) | (AW'(beat_q) << BYTE_OFF));
  assign rdata   = b_rdata;
  assign gnt     = state_q;
  assign amo_ack = lock_q && (state_q == GNT_D);

  // Next-state: arbitration, beat counting, lock handling.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    last_d_d = last_d_q;
    lock_d   = lock_q;
    active_d = active_q;
    unique case (state_q)
      IDLE: begin
        active_d = 1'b0;
        if (d_req && amo_req) begin
          state_d  = GNT_D;
          lock_d   = 1'b1;
          active_d = 1'b1;
        end else if (i_req && d_req) begin
          state_d  = last_d_q ? GNT_I : GNT_D;
          active_d = 1'b1;
        end else if (i_req) begin
          state_d  = GNT_I;
          active_d = 1'b1;
        end else if (d_req) begin
          state_d  = GNT_D;
          active_d = 1'b1;
        end
      end
      GNT_I, GNT_D: begin
        if (b_req_c && b_ack) begin
          if (beat_q == LAST_BEAT) begin
            beat_d   = '0;
            last_d_d = (state_q == GNT_D);
            active_d = 1'b0;
            if (!(lock_q && amo_req)) begin
              state_d = IDLE;
              lock_d  = 1'b0;
            end
          end else begin
            beat_d   = beat_q + BW'(1);
            active_d = 1'b1;
          end
        end else if (b_req_c) begin
          active_d = 1'b1;
        end else if (lock_q && !amo_req) begin
          // Lock released while no burst is in flight.
          state_d = IDLE;
          lock_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_arb.sv
module tb_bus_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we, amo_req, b_ack;
  logic [63:0] i_addr, d_addr, d_wdata, b_rdata;
  logic        i_ack, d_ack, amo_ack, b_req, b_we;
  logic [63:0] rdata, b_addr, b_wdata;
  logic [1:0]  gnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bus_arb #(.BEATS(8), .AW(64), .DW(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .amo_req(amo_req), .amo_ack(amo_ack), .rdata(rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_ack(b_ack), .gnt(gnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_inputs();
    i_req = 0; d_req = 0; d_we = 0; amo_req = 0; b_ack = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; b_rdata = '0;
  endtask

  // Ends on a negedge with the DUT idle; caller drives the next inputs there.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    b_rdata = 64'hABCD_1234_5678_9ABC;
    #1;
    check("rst_gnt", 64'(gnt), 0);
    check("rst_b_req", 64'(b_req), 0);
    check("rst_amo_ack", 64'(amo_ack), 0);
    check("rst_acks", {62'd0, i_ack, d_ack}, 0);
    check("rst_rdata", rdata, 64'hABCD_1234_5678_9ABC);

    // Address generation for an I burst.
    do_reset();
    i_req = 1; i_addr = 64'h1000_0047; b_ack = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("ag_breq%0d", k), 64'(b_req), 1);
      check($sformatf("ag_addr%0d", k), b_addr, 64'h1000_0040 + 64'(8 * k));
      check($sformatf("ag_iack%0d", k), 64'(i_ack), 1);
      check($sformatf("ag_gnt%0d", k), 64'(gnt), 1);
      if (k == 7) i_req = 0;
    end
    @(negedge clk);
    check("ag_idle_gnt", 64'(gnt), 0);
    check("ag_idle_breq", 64'(b_req), 0);

    // Round-robin: I, D, I, D with one idle cycle between grants.
    do_reset();
    i_req = 1; d_req = 1; b_ack = 1;
    i_addr = 64'h1100_0000; d_addr = 64'h2200_0000;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        check($sformatf("rr%0d_gnt%0d", r, k), 64'(gnt), (r % 2 == 0) ? 1 : 2);
        check($sformatf("rr%0d_ack%0d", r, k), {62'd0, i_ack, d_ack},
              (r % 2 == 0) ? 2 : 1);
        if (r == 3 && k == 7) begin i_req = 0; d_req = 0; end
      end
      @(negedge clk);
      check($sformatf("rr%0d_idle", r), {61'd0, gnt, b_req}, 0);
    end

    // Atomic lock: two back-to-back D bursts, I starved until release.
    do_reset();
    d_req = 1; d_we = 0; amo_req = 1; i_req = 1; b_ack = 1;
    d_addr = 64'h2000_0000; i_addr = 64'h3300_0000;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check($sformatf("lk_gnt%0d", k), 64'(gnt), 2);
      check($sformatf("lk_amo%0d", k), 64'(amo_ack), 1);
      check($sformatf("lk_ack%0d", k), {62'd0, i_ack, d_ack}, 1);
      check($sformatf("lk_addr%0d", k), b_addr, 64'h2000_0000 + 64'(8 * (k % 8)));
      if (k == 15) begin amo_req = 0; d_req = 0; end
    end
    @(negedge clk);
    check("lk_rel_gnt", 64'(gnt), 0);
    check("lk_rel_amo", 64'(amo_ack), 0);
    @(negedge clk);
    check("lk_then_i", 64'(gnt), 1);
    check("lk_then_iaddr", b_addr, 64'h3300_0000);

    // Lock idles between bursts, then releases outside a burst.
    do_reset();
    d_req = 1; amo_req = 1; b_ack = 1; d_addr = 64'h2400_0000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 7) d_req = 0;
    end
    @(negedge clk);
    check("lw_gnt", 64'(gnt), 2);
    check("lw_breq", 64'(b_req), 0);
    check("lw_dack", 64'(d_ack), 0);
    check("lw_amo", 64'(amo_ack), 1);
    amo_req = 0;
    @(negedge clk);
    check("lw_rel", {61'd0, gnt, amo_ack}, 0);

    // Lock requested during an I burst.
    do_reset();
    i_req = 1; i_addr = 64'h3000_0000; b_ack = 1; d_addr = 64'h4400_0000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("li_gnt%0d", k), 64'(gnt), 1);
      check($sformatf("li_amo%0d", k), 64'(amo_ack), 0);
      check($sformatf("li_iack%0d", k), 64'(i_ack), 1);
      if (k == 3) begin amo_req = 1; d_req = 1; d_we = 0; end
      if (k == 7) i_req = 0;
    end
    @(negedge clk);
    check("li_idle", {61'd0, gnt, amo_ack}, 0);
    @(negedge clk);
    check("li_gntd", 64'(gnt), 2);
    check("li_amo", 64'(amo_ack), 1);
    check("li_dack", 64'(d_ack), 1);

    // Write burst with wait states at beat 2.
    do_reset();
    d_req = 1; d_we = 1; d_addr = 64'h4000_0080; d_wdata = 64'h1111; b_ack = 1;
    @(negedge clk);
    check("wr_addr0", b_addr, 64'h4000_0080);
    @(negedge clk);
    check("wr_addr1", b_addr, 64'h4000_0088);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      b_ack = 0;
      d_wdata = 64'hA000 + 64'(k);
      #1;
      check($sformatf("ws_addr%0d", k), b_addr, 64'h4000_0090);
      check($sformatf("ws_we%0d", k), 64'(b_we), 1);
      check($sformatf("ws_dack%0d", k), 64'(d_ack), 0);
      check($sformatf("ws_wdata%0d", k), b_wdata, 64'hA000 + 64'(k));
    end
    @(negedge clk);
    b_ack = 1;
    #1;
    check("ws_resume_addr", b_addr, 64'h4000_0090);
    check("ws_resume_dack", 64'(d_ack), 1);
    @(negedge clk);
    check("ws_next_addr", b_addr, 64'h4000_0098);

    // Reset in the middle of a burst.
    do_reset();
    i_req = 1; i_addr = 64'h5000_0000; b_ack = 1;
    for (int k = 0; k < 5; k++) @(negedge clk);
    check("mr_beat4", b_addr, 64'h5000_0020);
    rst_n = 0;
    #1;
    check("mr_breq", 64'(b_req), 0);
    check("mr_gnt", 64'(gnt), 0);
    check("mr_amo", 64'(amo_ack), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("mr_restart_gnt", 64'(gnt), 1);
    check("mr_restart_addr", b_addr, 64'h5000_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bus_arb.md
Name: bus_arb

Overview:
- Arbitrates the hart's single external memory bus between the instruction-fetch refill port (I) and the data refill/writeback port (D).
- Each grant is a fixed-length line burst. The arbiter generates per-beat addresses and steers the per-beat acknowledges.
- Supports an atomic lock: the D port keeps the bus across multiple bursts while amo_req is held. amo_ack is the signal the hart control unit waits on before un-stalling.

Parameters:
- BEATS, 8: beats per line burst; power of two, ≥2.
- AW, 64: address width.
- DW, 64: data width; beat stride is DW/8 bytes.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_req  in  1  I-port burst request
- i_addr  in  AW  I-port line address; offset bits ignored
- i_ack  out  1  I-port beat acknowledge
- d_req  in  1  D-port burst request
- d_we  in  1  D-port burst is a write
- d_addr  in  AW  D-port line address; offset bits ignored
- d_wdata  in  DW  D-port write data for the current beat
- d_ack  out  1  D-port beat acknowledge
- amo_req  in  1  atomic lock request (D side)
- amo_ack  out  1  lock held by D
- rdata  out  DW  read data, combinational pass-through of b_rdata
- b_req  out  1  external bus cycle valid
- b_we  out  1  external write
- b_addr  out  AW  external beat address
- b_wdata  out  DW  external write data
- b_rdata  in  DW  external read data
- b_ack  in  1  external beat complete
- gnt  out  2  status: 00 idle, 01 I, 10 D

Behaviour:
- Decided interface: one clock; reset is asynchronous and active-low, ports clk and rst_n.

Reset (async, rst_n low):
- state=IDLE, beat=0, last=D, lock=0.
- All outputs 0, except rdata, which follows b_rdata.

States: IDLE, GNT_I, GNT_D.

IDLE:
- b_req=0; b_ack is ignored.
- Next-state decision:
  - d_req && amo_req: go to GNT_D, set lock=1.
  - Both requests pending: grant the port ≠ last, so I wins the first tie after reset.
  - Single request pending: grant it.
  - No requests: stay in IDLE.
- The grant is registered, so b_req rises the cycle after the request is seen. Minimum request-to-b_req latency is 1 cycle.

GNT_x:
- b_req=1.
- b_addr = {x_addr[AW-1:log2(BEATS*DW/8)], beat, zero byte offset}.
- b_we = d_we in GNT_D, 0 in GNT_I.
- b_wdata = d_wdata.
- x_ack = b_ack (combinational, only for the granted port); the other port's ack is 0.
- On b_ack: beat increments. On the final beat (beat==BEATS-1): beat←0, last←x, then:
  - If lock && amo_req: stay in GNT_D, with b_req held for the next burst only if d_req is high; otherwise b_req=0 while the lock is held.
  - Otherwise: go to IDLE and clear lock.
- Wait states: while b_ack=0, b_addr, b_we and beat are held stable and no x_ack is issued.
- The requester must hold req, addr and we stable until its final ack. Deasserting req mid-burst does not abort the burst.

Lock and amo_ack:
- amo_ack = lock && state==GNT_D (registered, so visible from the first GNT_D cycle).
- amo_req deasserted outside a burst → IDLE the next cycle, lock cleared.
- amo_req deasserted mid-burst → the burst completes, then IDLE.
- amo_req raised during an I burst → the I burst completes. D gets the lock on the next arbitration; amo_ack stays 0 until then.
- While the lock is held, i_req is never granted.

Simultaneous and boundary cases:
- b_ack on the final beat together with new requests: IDLE is always visited for one cycle with b_req=0, except for the locked D path.
- beat wraps only via the final-beat rule; it never exceeds BEATS-1.

Test Plan:
- Address generation: i_req=1, i_addr=0x1000_0047, b_ack=1 every cycle → b_req rises 1 cycle later; b_addr 0x1000_0040, 0x48 … 0x78; 8 i_ack pulses; then gnt=00 for one cycle with b_req=0.
- Round-robin fairness: from reset, raise i_req and d_req in the same cycle and keep both raised across two rounds → grants I, D, I, D in that order, each separated by one IDLE cycle.
- Atomic lock, two D bursts: d_req=1, d_we=0, amo_req=1, with i_req=1 → amo_ack=1 from the first GNT_D cycle; two back-to-back D bursts (16 d_ack), no i_ack; amo_req dropped → next cycle IDLE, then I is granted.
- Lock raised during an I burst: amo_req and d_req rise at the I burst's beat 3 → amo_ack stays 0 through the remaining 5 i_ack pulses, then GNT_D and amo_ack=1.
- Write burst with wait states: D write with b_ack held low 5 cycles at beat 2 → b_addr, b_we=1 and beat stable, no d_ack; b_wdata tracks d_wdata.
- Reset mid-burst: rst_n pulled low at beat 4 → b_req, gnt and amo_ack go to 0 asynchronously; after release with i_req held, the burst restarts at beat 0.
